// File: rtl/program_writer_if.sv
// Host-side request channel and program-memory write port of the nic8 program writer.
interface program_writer_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  reqValid;
  logic                  reqReady;
  logic [2:0]            reqDest;
  logic [2:0]            reqSource;
  logic                  reqBit3;
  logic                  reqBit7;
  logic [7:0]            reqImm;
  logic                  loadAddr;
  logic [ADDR_WIDTH-1:0] startAddr;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [7:0]            memData;
  logic                  memWe;
  logic                  illegalOp;
  logic                  wrapped;

  // Host / test side
  modport master (
    output reqValid, reqDest, reqSource, reqBit3, reqBit7, reqImm, loadAddr, startAddr,
    input  reqReady, memAddr, memData, memWe, illegalOp, wrapped
  );

  // Writer side
  modport slave (
    input  reqValid, reqDest, reqSource, reqBit3, reqBit7, reqImm, loadAddr, startAddr,
    output reqReady, memAddr, memData, memWe, illegalOp, wrapped
  );
endinterface

// File: rtl/program_writer.sv
// nic8 instruction encoder: packs {bit7, dest, bit3, source} into an opcode byte and writes it,
// plus an optional immediate byte, into program memory at an auto-incrementing address.
module program_writer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [2:0]  IMM_SOURCE = 3'd0
) (
  input  logic            clk,
  input  logic            resetBar,
  program_writer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOpcode, StImm} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [7:0]            r_mem_data, w_mem_data_next;
  logic                  r_mem_we, w_mem_we_next;
  logic                  r_illegal, w_illegal_next;
  logic                  r_wrapped, w_wrapped_next;
  logic [7:0]            r_imm;
  logic                  r_has_imm;

  logic                  w_idle;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_req_illegal;
  logic                  w_take;
  logic [7:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_idle        = (r_state == StIdle);
  assign w_load        = w_idle & bus.loadAddr;
  // loadAddr blocks the handshake so a load and an accept never share a cycle
  assign w_accept      = w_idle & ~bus.loadAddr & bus.reqValid;
  assign w_req_illegal = (bus.reqDest == 3'd0) | (bus.reqSource[2:1] == 2'b11) |
                         (bus.reqBit7 & (bus.reqDest != 3'd5));
  assign w_take        = w_accept & ~w_req_illegal;
  assign w_opcode      = {bus.reqBit7, bus.reqDest, bus.reqBit3, bus.reqSource};
  assign w_addr_inc    = r_addr + 1'b1;

  // State register
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_take) w_state_next = StOpcode;
      StOpcode: w_state_next = r_has_imm ? StImm : StIdle;
      StImm:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Next values of the registered write port, counter and status flags
  always_comb begin
    w_mem_we_next   = 1'b0;
    w_mem_addr_next = r_mem_addr;
    w_mem_data_next = r_mem_data;
    w_illegal_next  = 1'b0;
    w_addr_next     = r_addr;
    w_wrapped_next  = r_wrapped;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_addr_next    = bus.startAddr;
          w_wrapped_next = 1'b0;
        end else if (w_accept) begin
          if (w_req_illegal) begin
            w_illegal_next = 1'b1;
          end else begin
            w_mem_we_next   = 1'b1;
            w_mem_addr_next = r_addr;
            w_mem_data_next = w_opcode;
          end
        end
      end
      StOpcode: begin
        w_addr_next = w_addr_inc;
        if (&r_addr) w_wrapped_next = 1'b1;
        // Immediate goes to the address following the opcode
        if (r_has_imm) begin
          w_mem_we_next   = 1'b1;
          w_mem_addr_next = w_addr_inc;
          w_mem_data_next = r_imm;
        end
      end
      StImm: begin
        w_addr_next = w_addr_inc;
        if (&r_addr) w_wrapped_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, address counter and latched request fields
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_illegal  <= 1'b0;
      r_wrapped  <= 1'b0;
      r_imm      <= '0;
      r_has_imm  <= 1'b0;
    end else begin
      r_addr     <= w_addr_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_data <= w_mem_data_next;
      r_mem_we   <= w_mem_we_next;
      r_illegal  <= w_illegal_next;
      r_wrapped  <= w_wrapped_next;
      if (w_take) begin
        r_imm     <= bus.reqImm;
        r_has_imm <= (bus.reqSource == IMM_SOURCE);
      end
    end
  end

  assign bus.reqReady  = w_idle & ~bus.loadAddr;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memData   = r_mem_data;
  assign bus.memWe     = r_mem_we;
  assign bus.illegalOp = r_illegal;
  assign bus.wrapped   = r_wrapped;

endmodule
